instr_fetch_unit: RTL and testbench

Instruction fetch stage for the RISC-V single-cycle core. Holds the program counter, issues word reads to instruction memory over a req/ready handshake, and presents one registered instruction at a time to the decode stage; its `op` field drives the main decoder. On each accepted instruction the next PC is computed as PC+4 or the branch/jump target selected by `PCSrc`.

---
 rtl/instr_fetch_unit.sv | 105 ++++++++++
 tb/tb_instr_fetch_unit.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds PC, fetches one word over req/ready, presents it to decode.
// Optional build macro IFU_MISALIGN_TRAP_EN: misaligned branch target sets sticky flag and halts.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic [31:0] Instr,
    output logic [6:0]  op,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        misaligned
);

`ifdef IFU_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_HALT} state_t;
    logic misaligned_q;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;
`endif

    state_t state;

    assign imem_addr = PC;
    assign op        = Instr[6:0];
    assign PCPlus4   = PC + 32'd4;

`ifdef IFU_MISALIGN_TRAP_EN
    assign misaligned = misaligned_q;
`else
    logic unused_tgt_lo;
    assign misaligned    = 1'b0;
    assign unused_tgt_lo = ^PCTarget[1:0];
`endif

    // req/valid are registered alongside the state so they are glitch-free to memory/decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            PC          <= RESET_PC;
            Instr       <= NOP_INSTR;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            misaligned_q <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        Instr       <= imem_rdata;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                        state       <= S_VALID;
                    end
                end
                S_VALID: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
                        if (PCSrc && (PCTarget[1:0] != 2'b00)) begin
                            misaligned_q <= 1'b1;
                            PC           <= PCTarget;
                            state        <= S_HALT;
                        end else begin
                            PC       <= PCSrc ? PCTarget : PCPlus4;
                            imem_req <= 1'b1;
                            state    <= S_FETCH;
                        end
`else
                        PC       <= PCSrc ? {PCTarget[31:2], 2'b00} : PCPlus4;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
`endif
                    end
                end
`ifdef IFU_MISALIGN_TRAP_EN
                S_HALT: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
`endif
                default: begin
                    state       <= S_IDLE;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; the misalign step follows IFU_MISALIGN_TRAP_EN.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic        PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] Instr;
    logic [6:0]  op;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        misaligned;

    int total = 0;
    int bad   = 0;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PCSrc       (PCSrc),
        .PCTarget    (PCTarget),
        .Instr       (Instr),
        .op          (op),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .misaligned  (misaligned)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        PCTarget    = 32'h0;
        tick;
        tick;

        check("rst_req",   {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_pc",    PC, 32'h0);
        check("rst_addr",  imem_addr, 32'h0);
        check("rst_pc4",   PCPlus4, 32'h4);
        check("rst_instr", Instr, 32'h0000_0013);
        check("rst_op",    {25'b0, op}, 32'h13);
        check("rst_mis",   {31'b0, misaligned}, 32'h0);

        // reset release with zero-wait memory
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h0020_81B3;
        tick;
        check("first_req",   {31'b0, imem_req}, 32'h1);
        check("first_addr",  imem_addr, 32'h0);
        check("first_nval",  {31'b0, instr_valid}, 32'h0);
        tick;
        check("first_valid", {31'b0, instr_valid}, 32'h1);
        check("first_req0",  {31'b0, imem_req}, 32'h0);
        check("first_instr", Instr, 32'h0020_81B3);
        check("first_op",    {25'b0, op}, 32'h33);
        check("first_pc4",   PCPlus4, 32'h4);

        // decode backpressure; memory inputs wiggle and must be ignored
        for (int i = 0; i < 5; i++) begin
            imem_rdata = 32'hDEAD_BE00 + i;
            tick;
            check("bp_instr", Instr, 32'h0020_81B3);
            check("bp_pc",    PC, 32'h0);
            check("bp_req",   {31'b0, imem_req}, 32'h0);
            check("bp_valid", {31'b0, instr_valid}, 32'h1);
        end

        // accept with redirect to 0x40, then three wait cycles
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'h40;
        imem_ready  = 1'b0;
        tick;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        check("ws_req",  {31'b0, imem_req}, 32'h1);
        check("ws_addr", imem_addr, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick;
            check("ws_req_hold",  {31'b0, imem_req}, 32'h1);
            check("ws_addr_hold", imem_addr, 32'h40);
            check("ws_nval",      {31'b0, instr_valid}, 32'h0);
        end
        imem_ready = 1'b1;
        imem_rdata = 32'h0000_0063;
        tick;
        check("ws_valid", {31'b0, instr_valid}, 32'h1);
        check("ws_pc",    PC, 32'h40);
        check("ws_pc4",   PCPlus4, 32'h44);
        check("ws_op",    {25'b0, op}, 32'h63);

        // branch redirect at 0x40 -> 0x10
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'h10;
        tick;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        check("br_req",  {31'b0, imem_req}, 32'h1);
        check("br_addr", imem_addr, 32'h10);
        tick;
        check("br_valid", {31'b0, instr_valid}, 32'h1);
        check("br_pc",    PC, 32'h10);

        // back to 0x40, then sequential accept -> 0x44
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'h40;
        tick;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        check("ret_addr", imem_addr, 32'h40);
        tick;
        instr_ready = 1'b1;
        PCSrc       = 1'b0;
        PCTarget    = 32'h10;
        tick;
        instr_ready = 1'b0;
        check("seq_addr", imem_addr, 32'h44);
        check("seq_req",  {31'b0, imem_req}, 32'h1);
        tick;
        check("seq_pc", PC, 32'h44);

        // wrap at top of address space
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'hFFFF_FFFC;
        tick;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        tick;
        check("top_pc4", PCPlus4, 32'h0);
        instr_ready = 1'b1;
        tick;
        instr_ready = 1'b0;
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_req",  {31'b0, imem_req}, 32'h1);

        // reset in FETCH while memory answers: data discarded
        rst_n      = 1'b0;
        imem_rdata = 32'h1234_5678;
        tick;
        check("mrst_instr", Instr, 32'h0000_0013);
        check("mrst_valid", {31'b0, instr_valid}, 32'h0);
        check("mrst_req",   {31'b0, imem_req}, 32'h0);
        check("mrst_pc",    PC, 32'h0);
        rst_n = 1'b1;
        tick;
        check("rel_req", {31'b0, imem_req}, 32'h1);
        tick;
        check("rel_instr", Instr, 32'h1234_5678);

        // misaligned branch target
        instr_ready = 1'b1;
        PCSrc       = 1'b1;
        PCTarget    = 32'h102;
        tick;
        instr_ready = 1'b0;
        PCSrc       = 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
        check("mis_flag",  {31'b0, misaligned}, 32'h1);
        check("mis_pc",    PC, 32'h102);
        for (int i = 0; i < 3; i++) begin
            check("mis_req",   {31'b0, imem_req}, 32'h0);
            check("mis_valid", {31'b0, instr_valid}, 32'h0);
            tick;
        end
        check("mis_sticky", {31'b0, misaligned}, 32'h1);
`else
        check("mis_addr", imem_addr, 32'h100);
        check("mis_req",  {31'b0, imem_req}, 32'h1);
        check("mis_flag", {31'b0, misaligned}, 32'h0);
        tick;
        check("mis_pc", PC, 32'h100);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
